// File: rtl/axi4lite_native_bridge_if.sv
// Bus bundle between an AXI4-Lite master and the native memory port.
// The slave modport is the bridge's own view of the bundle.
interface axi4lite_native_bridge_if;
   logic        s_awvalid;
   logic        s_awready;
   logic [31:0] s_awaddr;
   logic [2:0]  s_awprot;
   logic        s_wvalid;
   logic        s_wready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_bvalid;
   logic        s_bready;
   logic [1:0]  s_bresp;
   logic        s_arvalid;
   logic        s_arready;
   logic [31:0] s_araddr;
   logic [2:0]  s_arprot;
   logic        s_rvalid;
   logic        s_rready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        mem_valid;
   logic        mem_instr;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport slave (
      input  s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata, s_wstrb, s_bready,
      input  s_arvalid, s_araddr, s_arprot, s_rready, mem_ready, mem_rdata,
      output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp,
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata, s_wstrb, s_bready,
      output s_arvalid, s_araddr, s_arprot, s_rready, mem_ready, mem_rdata,
      input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp,
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/axi4lite_native_bridge.sv
// AXI4-Lite slave feeding a single-outstanding native memory bus, with
// one-deep AW/W/AR holding registers, round-robin arbitration and optional timeout.
module axi4lite_native_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic                           clk,
   input  logic                           reset,
   axi4lite_native_bridge_if.slave        bus,
   output logic [2:0]                     dbg_state
);
   typedef enum logic [2:0] {IDLE, RD, WR, RRESP, BRESP} state_t;

   localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

   state_t      state, state_n;
   logic        aw_full, w_full, ar_full;
   logic [31:0] aw_addr, w_data, ar_addr;
   logic [3:0]  w_strb;
   logic        ar_instr;
   logic        rd_first;
   logic [31:0] to_cnt;
   logic        rd_pend, wr_pend, to_hit;
   logic        start_rd, start_wr, done, timed_out;
   logic        unused_prot;

   assign unused_prot = ^{bus.s_awprot, bus.s_arprot[1:0]};

   // Every channel transfers on the rising edge where valid && ready are both
   // high; a source holds valid and payload until then, ready never waits on valid.
   assign bus.s_awready = !aw_full && !reset;
   assign bus.s_wready  = !w_full  && !reset;
   assign bus.s_arready = !ar_full && !reset;

   assign rd_pend   = ar_full;
   assign wr_pend   = aw_full && w_full;
   assign to_hit    = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      start_rd  = 1'b0;
      start_wr  = 1'b0;
      done      = 1'b0;
      timed_out = 1'b0;
      case (state)
         IDLE: begin
            if (rd_pend && (!wr_pend || rd_first)) begin
               state_n  = RD;
               start_rd = 1'b1;
            end else if (wr_pend) begin
               state_n  = WR;
               start_wr = 1'b1;
            end
         end
         // mem_valid is high for the whole of RD/WR, so mem_ready is always meaningful here
         RD, WR: begin
            if (bus.mem_ready) begin
               done    = 1'b1;
               state_n = (state == RD) ? RRESP : BRESP;
            end else if (to_hit) begin
               timed_out = 1'b1;
               state_n   = (state == RD) ? RRESP : BRESP;
            end
         end
         RRESP:   if (bus.s_rready) state_n = IDLE;
         BRESP:   if (bus.s_bready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         aw_full       <= 1'b0;
         w_full        <= 1'b0;
         ar_full       <= 1'b0;
         aw_addr       <= '0;
         w_data        <= '0;
         w_strb        <= '0;
         ar_addr       <= '0;
         ar_instr      <= 1'b0;
         rd_first      <= 1'b1;
         to_cnt        <= '0;
         bus.mem_valid <= 1'b0;
         bus.mem_instr <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wstrb <= '0;
         bus.s_rvalid  <= 1'b0;
         bus.s_rdata   <= '0;
         bus.s_rresp   <= '0;
         bus.s_bvalid  <= 1'b0;
         bus.s_bresp   <= '0;
      end else begin
         if (bus.s_awvalid && bus.s_awready) begin
            aw_full <= 1'b1;
            aw_addr <= bus.s_awaddr;
         end
         if (bus.s_wvalid && bus.s_wready) begin
            w_full <= 1'b1;
            w_data <= bus.s_wdata;
            w_strb <= bus.s_wstrb;
         end
         if (bus.s_arvalid && bus.s_arready) begin
            ar_full  <= 1'b1;
            ar_addr  <= bus.s_araddr;
            ar_instr <= bus.s_arprot[2];
         end

         if (start_rd) begin
            bus.mem_valid <= 1'b1;
            bus.mem_addr  <= ar_addr;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= 4'b0000;
            bus.mem_instr <= ar_instr;
         end
         if (start_wr) begin
            bus.mem_valid <= 1'b1;
            bus.mem_addr  <= aw_addr;
            bus.mem_wdata <= w_data;
            bus.mem_wstrb <= w_strb;
            bus.mem_instr <= 1'b0;
         end

         // The pointer only moves when it actually decided a contest
         if (start_rd || start_wr) begin
            to_cnt <= '0;
            if (rd_pend && wr_pend) rd_first <= !rd_first;
         end else if (state == RD || state == WR) begin
            to_cnt <= to_cnt + 32'd1;
         end

         if (done || timed_out) begin
            bus.mem_valid <= 1'b0;
            if (state == RD) begin
               ar_full      <= 1'b0;
               bus.s_rvalid <= 1'b1;
               bus.s_rdata  <= done ? bus.mem_rdata : 32'd0;
               bus.s_rresp  <= done ? 2'b00 : 2'b10;
            end else begin
               aw_full      <= 1'b0;
               w_full       <= 1'b0;
               bus.s_bvalid <= 1'b1;
               bus.s_bresp  <= done ? 2'b00 : 2'b10;
            end
         end

         if (state == RRESP && bus.s_rready) bus.s_rvalid <= 1'b0;
         if (state == BRESP && bus.s_bready) bus.s_bvalid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_axi4lite_native_bridge.sv
// Randomised and directed bench for axi4lite_native_bridge against a
// transaction-level memory model and an expected native-request queue.
`timescale 1ns/1ps
module tb_axi4lite_native_bridge;
   localparam int TO = 8;
   localparam int W  = 69;   // {instr, wstrb, addr, wdata}

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   axi4lite_native_bridge_if bus();

   axi4lite_native_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [W-1:0] exp_q[$];
   logic [31:0] dev_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   bit          mem_stall = 1'b0;
   int          max_delay = 0;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'hc0de_0000 ^ {a[15:0], a[31:16]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Native memory responder: random latency, checks each completed request in order
   initial begin : responder
      bit          busy;
      int          delay;
      logic [W-1:0] got, e;
      logic [31:0] old;
      busy = 1'b0;
      delay = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_ready = 1'b0;
         bus.mem_rdata = $urandom;
         if (reset || !bus.mem_valid) begin
            busy = 1'b0;
         end else if (!mem_stall) begin
            if (!busy) begin
               busy  = 1'b1;
               delay = $urandom_range(0, max_delay);
            end
            if (delay == 0) begin
               busy = 1'b0;
               bus.mem_ready = 1'b1;
               got = {bus.mem_instr, bus.mem_wstrb, bus.mem_addr,
                      (bus.mem_wstrb == 4'b0) ? 32'd0 : bus.mem_wdata};
               e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
               check_eq("native_req", got, e);
               old = dev_mem.exists(bus.mem_addr) ? dev_mem[bus.mem_addr] : dflt(bus.mem_addr);
               if (bus.mem_wstrb == 4'b0) bus.mem_rdata = old;
               else dev_mem[bus.mem_addr] = merge(old, bus.mem_wdata, bus.mem_wstrb);
            end else begin
               delay--;
            end
         end
      end
   end

   task automatic send_aw(input logic [31:0] a);
      int n = 0;
      bus.s_awvalid = 1'b1;
      bus.s_awaddr  = a;
      bus.s_awprot  = 3'($urandom_range(0, 7));
      forever begin
         @(negedge clk);
         if (bus.s_awready) break;
         if (++n > 50) begin
            check_eq("aw_hs_timeout", n, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.s_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      bus.s_wvalid = 1'b1;
      bus.s_wdata  = d;
      bus.s_wstrb  = s;
      forever begin
         @(negedge clk);
         if (bus.s_wready) break;
         if (++n > 50) begin
            check_eq("w_hs_timeout", n, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.s_wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a, input logic [2:0] p);
      int n = 0;
      bus.s_arvalid = 1'b1;
      bus.s_araddr  = a;
      bus.s_arprot  = p;
      forever begin
         @(negedge clk);
         if (bus.s_arready) break;
         if (++n > 50) begin
            check_eq("ar_hs_timeout", n, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.s_arvalid = 1'b0;
   endtask

   task automatic get_r(input string tag, input logic [31:0] ed, input logic [1:0] er, input int hold);
      int n = 0;
      while (!bus.s_rvalid && n < 100) begin
         tick(1);
         n++;
      end
      check_eq({tag, "_rvalid"}, bus.s_rvalid, 1);
      for (int i = 0; i < hold; i++) begin
         tick(1);
         check_eq({tag, "_rhold"}, {bus.s_rvalid, bus.mem_valid, bus.s_rdata}, {1'b1, 1'b0, ed});
      end
      check_eq({tag, "_rdata"}, bus.s_rdata, ed);
      check_eq({tag, "_rresp"}, bus.s_rresp, er);
      bus.s_rready = 1'b1;
      tick(1);
      bus.s_rready = 1'b0;
      check_eq({tag, "_rclr"}, bus.s_rvalid, 0);
   endtask

   task automatic get_b(input string tag, input logic [1:0] er, input int hold);
      int n = 0;
      while (!bus.s_bvalid && n < 100) begin
         tick(1);
         n++;
      end
      check_eq({tag, "_bvalid"}, bus.s_bvalid, 1);
      for (int i = 0; i < hold; i++) begin
         tick(1);
         check_eq({tag, "_bhold"}, {bus.s_bvalid, bus.mem_valid, bus.s_bresp}, {1'b1, 1'b0, er});
      end
      check_eq({tag, "_bresp"}, bus.s_bresp, er);
      bus.s_bready = 1'b1;
      tick(1);
      bus.s_bready = 1'b0;
      check_eq({tag, "_bclr"}, bus.s_bvalid, 0);
   endtask

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      exp_q.push_back({1'b0, s, a, d});
      ref_mem[a] = merge(ref_rd(a), d, s);
   endtask

   task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int ga = $urandom_range(0, 3);
      int gw = $urandom_range(0, 3);
      model_write(a, d, s);
      fork
         begin tick(ga); send_aw(a); end
         begin tick(gw); send_w(d, s); end
      join
      get_b(tag, 2'b00, $urandom_range(0, 3));
   endtask

   task automatic do_read(input string tag, input logic [31:0] a, input logic [2:0] p);
      logic [31:0] ed = ref_rd(a);
      exp_q.push_back({p[2], 4'b0, a, 32'd0});
      send_ar(a, p);
      get_r(tag, ed, 2'b00, $urandom_range(0, 3));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int k;
      int hv;
      logic [31:0] d1;
      bus.s_awvalid = 0; bus.s_awaddr = 0; bus.s_awprot = 0;
      bus.s_wvalid = 0;  bus.s_wdata = 0;  bus.s_wstrb = 0;
      bus.s_arvalid = 0; bus.s_araddr = 0; bus.s_arprot = 0;
      bus.s_bready = 0;  bus.s_rready = 0;

      // Reset state
      tick(3);
      check_eq("rst_readies", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b000);
      check_eq("rst_valids", {bus.mem_valid, bus.s_rvalid, bus.s_bvalid}, 3'b000);
      check_eq("rst_mem", {bus.mem_instr, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata}, 0);
      reset = 1'b0;
      tick(1);
      check_eq("post_rst_readies", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b111);
      check_eq("post_rst_state", dbg_state, 0);

      // Minimum-latency instruction fetch
      max_delay = 0;
      dev_mem[32'h100] = 32'h1234_5678;
      ref_mem[32'h100] = 32'h1234_5678;
      exp_q.push_back({1'b1, 4'b0, 32'h100, 32'd0});
      send_ar(32'h100, 3'b100);
      k = 0;
      while (!bus.s_rvalid && k < 20) begin
         tick(1);
         k++;
      end
      check_eq("rd_latency", k, 2);
      get_r("rd1", 32'h1234_5678, 2'b00, 0);

      // W three cycles ahead of AW, slow B acceptance
      model_write(32'h200, 32'hA5A5_A5A5, 4'b0101);
      send_w(32'hA5A5_A5A5, 4'b0101);
      tick(3);
      check_eq("w_only_no_req", bus.mem_valid, 0);
      send_aw(32'h200);
      k = 0;
      while (!bus.s_bvalid && k < 20) begin
         tick(1);
         k++;
      end
      check_eq("wr_latency", k, 2);
      get_b("wr1", 2'b00, 5);
      check_eq("wr1_q_drain", exp_q.size(), 0);
      do_read("wr1_rb", 32'h200, 3'b000);

      // Round-robin: first contest goes to the read, the next one to the write
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(1);
      d1 = ref_rd(32'h300);
      exp_q.push_back({1'b1, 4'b0, 32'h300, 32'd0});
      model_write(32'h300, 32'h1111_2222, 4'b1111);
      fork
         send_ar(32'h300, 3'b100);
         send_aw(32'h300);
         send_w(32'h1111_2222, 4'b1111);
      join
      get_r("arb1", d1, 2'b00, 0);
      get_b("arb1", 2'b00, 0);
      model_write(32'h300, 32'h3333_4444, 4'b0011);
      exp_q.push_back({1'b1, 4'b0, 32'h300, 32'd0});
      fork
         send_ar(32'h300, 3'b100);
         send_aw(32'h300);
         send_w(32'h3333_4444, 4'b0011);
      join
      get_b("arb2", 2'b00, 0);
      get_r("arb2", ref_rd(32'h300), 2'b00, 0);
      check_eq("arb_q_drain", exp_q.size(), 0);

      // Timeout on a stalled read, then a normal read
      mem_stall = 1'b1;
      send_ar(32'h400, 3'b000);
      hv = 0;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (bus.mem_valid) hv++;
         if (bus.s_rvalid) break;
      end
      check_eq("to_valid_cycles", hv, TO);
      get_r("to", 32'd0, 2'b10, 0);
      mem_stall = 1'b0;
      max_delay = 2;
      do_read("to_next", 32'h404, 3'b000);

      // Second AR accepted while R is back-pressured, issued only after R handshake
      exp_q.push_back({1'b0, 4'b0, 32'h500, 32'd0});
      send_ar(32'h500, 3'b000);
      k = 0;
      while (!bus.s_rvalid && k < 20) begin
         tick(1);
         k++;
      end
      exp_q.push_back({1'b1, 4'b0, 32'h504, 32'd0});
      send_ar(32'h504, 3'b100);
      check_eq("ar2_blocked", bus.s_arready, 0);
      get_r("bp1", ref_rd(32'h500), 2'b00, 10);
      get_r("bp2", ref_rd(32'h504), 2'b00, 0);

      // Reset while a write is on the native bus
      mem_stall = 1'b1;
      fork
         send_aw(32'h600);
         send_w(32'hDEAD_BEEF, 4'b1111);
      join
      k = 0;
      while (!bus.mem_valid && k < 20) begin
         tick(1);
         k++;
      end
      check_eq("rst_wr_active", bus.mem_valid, 1);
      tick(2);
      reset = 1'b1;
      tick(1);
      check_eq("rst_wr_valids", {bus.mem_valid, bus.s_bvalid}, 2'b00);
      check_eq("rst_wr_readies", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b000);
      reset = 1'b0;
      mem_stall = 1'b0;
      hv = 0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         if (bus.mem_valid) hv++;
      end
      check_eq("rst_wr_dropped", hv, 0);
      do_write("rst_fresh", 32'h604, 32'h0BAD_F00D, 4'b1001);
      do_read("rst_fresh_rb", 32'h604, 3'b000);

      // Randomised mix against the transaction-level model
      max_delay = 4;
      for (int t = 0; t < 40; t++) begin
         logic [31:0] a;
         a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1)
            do_write("rnd_wr", a, $urandom, 4'($urandom_range(1, 15)));
         else
            do_read("rnd_rd", a, 3'($urandom_range(0, 7)));
         tick($urandom_range(0, 2));
      end
      tick(5);
      check_eq("final_q_drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/axi4lite_native_bridge.md
Name: axi4lite_native_bridge

Overview:
- AXI4-Lite slave to native single-port memory bus (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_instr/mem_rdata).
- Sits directly downstream of the core's AXI master port and upstream of a simple memory or MMIO model.
- Captures AW, W and AR independently in one-deep holding registers.
- Serialises transfers onto the native bus, one at a time, with round-robin read/write arbitration and an optional response timeout.

Parameters:
- TIMEOUT_CYCLES, 0: mem_valid cycles without mem_ready before an error response is returned; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_awaddr  in  32  write address
- s_awprot  in  3  write protection (ignored)
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_bresp  out  2  00 OKAY, 10 SLVERR
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_araddr  in  32  read address
- s_arprot  in  3  bit 2 marks an instruction fetch
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- s_rdata  out  32  read data
- s_rresp  out  2  00 OKAY, 10 SLVERR
- mem_valid  out  1  native request
- mem_instr  out  1  request is an instruction fetch
- mem_ready  in  1  native completion
- mem_addr  out  32  native address
- mem_wdata  out  32  native write data
- mem_wstrb  out  4  0000 = read, otherwise write strobes
- mem_rdata  in  32  native read data, valid when mem_ready is high

Behaviour:
- Reset: all valids, readies and responses go to 0; mem_* outputs go to 0; holding registers are emptied; FSM goes to IDLE; arbitration pointer is set to "read first".
- Reset mid-operation: the in-flight transfer is discarded with no AXI response; mem_valid is low in the cycle after reset is sampled.
- Holding registers:
  - s_awready = !aw_full && !reset; s_wready and s_arready follow the same rule for their own registers.
  - A holding register is loaded on its valid&&ready edge.
  - Holding registers keep accepting while a transfer is in flight.
  - AW and W may arrive in any order or in the same cycle.
- FSM states: IDLE, RD, WR, RRESP, BRESP. Only one native transfer is outstanding at a time.
- IDLE:
  - Read pending = ar_full. Write pending = aw_full && w_full.
  - Only one pending: go to that state.
  - Both pending: the arbitration pointer picks, then the pointer toggles to the other side.
  - On entry, mem_valid, mem_addr, mem_wstrb, mem_wdata and mem_instr are registered. For a read, mem_wstrb = 0 and mem_instr = arprot[2]; for a write, mem_instr = 0.
- RD and WR:
  - mem_* outputs are held stable while mem_valid is high.
  - On mem_ready: mem_valid drops next cycle and the holding register(s) are cleared.
  - RD: rdata <= mem_rdata, rresp = 00, then go to RRESP.
  - WR: bresp = 00, then go to BRESP.
  - mem_ready sampled while mem_valid is low is ignored.
- Timeout (TIMEOUT_CYCLES > 0):
  - A counter counts mem_valid cycles; it reaches TIMEOUT_CYCLES with no mem_ready.
  - On timeout: mem_valid drops and the response is SLVERR. A read returns rdata = 0.
  - A late mem_ready is ignored until the next transfer's mem_valid.
- RRESP and BRESP: s_rvalid/s_bvalid is held with stable data/resp until the handshake, then the FSM returns to IDLE.
- Minimum read latency:
  - AR handshake at edge E0; mem_valid high after E1.
  - With mem_ready high at E2, s_rvalid is high after E2.
- Minimum write latency: the same, counted from the later of the AW and W handshakes.
- Address passes through unmodified; no range check in this block.

Test Plan:
- Read: araddr=0x100, arprot=100, memory returns 0x12345678 with immediate mem_ready -> mem_instr=1, mem_wstrb=0000, s_rdata=0x12345678, s_rresp=00, s_rvalid exactly 2 edges after the AR handshake.
- Write with W 3 cycles before AW: wdata=0xA5A5A5A5, wstrb=0101, awaddr=0x200; bready held low 5 cycles -> exactly one native write with addr 0x200, data 0xA5A5A5A5, strobe 0101; s_bvalid held stable, then cleared after the handshake; bresp=00.
- Read and write both pending right after reset, scenario then repeated -> first round read before write; second round write before read.
- TIMEOUT_CYCLES=8, mem_ready tied low, read issued -> mem_valid high for exactly 8 cycles, then s_rresp=10 and s_rdata=0; the next transfer completes normally with OKAY.
- s_rready held low 10 cycles while a second AR is presented -> second AR accepted, then s_arready stays low; second mem_valid appears only after the first R handshake.
- Reset asserted in WR with mem_valid high -> next cycle mem_valid=0, s_bvalid=0, all readies 0; after release a fresh write completes normally.
